// File: rtl/demux_1_to_4_deser_if.sv
// Bus bundle between a serial bit source and demux_1_to_4_deser.
// master: drives in_bit/in_valid/sel/frame_sync; slave: drives out/out_valid/cur_sel/dup_err.
interface demux_1_to_4_deser_if #(
    parameter int LANES = 4,
    parameter int SEL_W = 2
);
    logic             in_bit;
    logic             in_valid;
    logic [SEL_W-1:0] sel;
    logic             frame_sync;
    logic [LANES-1:0] out;
    logic             out_valid;
    logic [SEL_W-1:0] cur_sel;
    logic             dup_err;

    modport master (
        output in_bit, in_valid, sel, frame_sync,
        input  out, out_valid, cur_sel, dup_err
    );

    modport slave (
        input  in_bit, in_valid, sel, frame_sync,
        output out, out_valid, cur_sel, dup_err
    );
endinterface

// File: rtl/demux_1_to_4_deser.sv
// Registered 1-to-LANES deserialiser: steers serial bits into lanes, publishes a word when all lanes are fresh.
// Ports: clk, rst (sync, active-high), bus (slave: in_bit/in_valid/sel/frame_sync in; out/out_valid/cur_sel/dup_err out).
module demux_1_to_4_deser #(
    parameter int LANES    = 4,
    parameter int SEL_W    = 2,
    parameter int AUTO_SEL = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    demux_1_to_4_deser_if.slave    bus
);
    logic [LANES-1:0] shadow_q;
    logic [LANES-1:0] mask_q;
    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] sel_q;
    logic [LANES-1:0] out_q;
    logic             out_valid_q;
    logic             dup_err_q;

    logic [SEL_W-1:0] lane;
    logic [LANES-1:0] mask_base;
    logic [LANES-1:0] shadow_base;
    logic [LANES-1:0] mask_nx;
    logic [LANES-1:0] shadow_nx;
    logic             dup;
    logic             full;

    always_comb begin
        lane        = '0;
        mask_base   = mask_q;
        shadow_base = shadow_q;
        dup         = 1'b0;
        if (!bus.frame_sync) begin
            lane = (AUTO_SEL != 0) ? cnt_q : bus.sel;
            dup  = mask_q[lane];
        end else begin
            // a frame start discards whatever partial frame was collected
            mask_base   = '0;
            shadow_base = '0;
        end
        mask_nx         = mask_base;
        mask_nx[lane]   = 1'b1;
        shadow_nx       = shadow_base;
        shadow_nx[lane] = bus.in_bit;
        // a duplicate leaves the mask unchanged, so it can never complete a frame
        full = &mask_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            sel_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            dup_err_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            dup_err_q   <= 1'b0;
            if (bus.in_valid) begin
                shadow_q  <= shadow_nx;
                mask_q    <= full ? '0 : mask_nx;
                dup_err_q <= dup;
                sel_q     <= bus.sel;
                if (AUTO_SEL != 0) begin
                    // LANES is a power of two, so the counter wraps on its own
                    cnt_q <= lane + 1'b1;
                end
                if (full) begin
                    out_q       <= shadow_nx;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dup_err   = dup_err_q;
    assign bus.cur_sel   = (AUTO_SEL != 0) ? cnt_q : sel_q;
endmodule

// File: tb/tb_demux_1_to_4_deser.sv
// Self-checking bench for demux_1_to_4_deser: auto-select and external-select instances side by side.
// Table vectors, directed corner sequences and random stimulus against a frame-level reference model.
module tb_demux_1_to_4_deser;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_bit;
    logic       in_valid;
    logic       frame_sync;
    logic [1:0] sel;

    always #5 clk = ~clk;

    demux_1_to_4_deser_if ifa ();
    demux_1_to_4_deser_if ifm ();

    assign ifa.in_bit     = in_bit;
    assign ifa.in_valid   = in_valid;
    assign ifa.sel        = sel;
    assign ifa.frame_sync = frame_sync;
    assign ifm.in_bit     = in_bit;
    assign ifm.in_valid   = in_valid;
    assign ifm.sel        = sel;
    assign ifm.frame_sync = frame_sync;

    demux_1_to_4_deser #(.LANES(4), .SEL_W(2), .AUTO_SEL(1)) u_auto (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    demux_1_to_4_deser #(.LANES(4), .SEL_W(2), .AUTO_SEL(0)) u_man (
        .clk (clk),
        .rst (rst),
        .bus (ifm.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: index 0 = auto-select DUT, 1 = external-select DUT.
    // A frame is the set of lane values received since the last publish/sync/reset (-1 = not yet seen).
    int         mv[2][4];
    logic [3:0] m_out[2];
    logic       m_ov[2];
    logic       m_dup[2];
    int         m_cnt[2];
    int         m_sel[2];

    function automatic void m_step();
        for (int d = 0; d < 2; d++) begin
            m_ov[d]  = 1'b0;
            m_dup[d] = 1'b0;
            if (rst) begin
                for (int i = 0; i < 4; i++) mv[d][i] = -1;
                m_out[d] = 4'd0;
                m_cnt[d] = 0;
                m_sel[d] = 0;
            end else if (in_valid) begin
                int  ln;
                bit  all;
                ln = frame_sync ? 0 : ((d == 0) ? m_cnt[d] : int'(sel));
                if (frame_sync) begin
                    for (int i = 0; i < 4; i++) mv[d][i] = -1;
                end else if (mv[d][ln] != -1) begin
                    m_dup[d] = 1'b1;
                end
                mv[d][ln] = int'(in_bit);
                all = 1'b1;
                for (int i = 0; i < 4; i++) if (mv[d][i] == -1) all = 1'b0;
                if (all) begin
                    for (int i = 0; i < 4; i++) m_out[d][i] = mv[d][i][0];
                    m_ov[d] = 1'b1;
                    for (int i = 0; i < 4; i++) mv[d][i] = -1;
                end
                m_cnt[d] = (ln + 1) % 4;
                m_sel[d] = int'(sel);
            end
        end
    endfunction

    task automatic cyc(bit r, bit v, bit b, logic [1:0] s, bit fs);
        rst        = r;
        in_valid   = v;
        in_bit     = b;
        sel        = s;
        frame_sync = fs;
        @(posedge clk);
        m_step();
        #1;
        chk("a_out", ifa.out, m_out[0]);
        chk("a_ov", ifa.out_valid, m_ov[0]);
        chk("a_dup", ifa.dup_err, m_dup[0]);
        chk("a_cur", ifa.cur_sel, m_cnt[0]);
        chk("m_out", ifm.out, m_out[1]);
        chk("m_ov", ifm.out_valid, m_ov[1]);
        chk("m_dup", ifm.dup_err, m_dup[1]);
        chk("m_cur", ifm.cur_sel, m_sel[1]);
    endtask

    typedef struct {
        bit         v;
        bit         b;
        logic [1:0] s;
        logic [3:0] eo;
        bit         eov;
        bit         edup;
    } vec_t;

    vec_t tv[$];

    initial begin
        int word;
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; sel = 2'd0; frame_sync = 1'b0;

        // external select: sel 3,0,2,1 with idle gaps, then duplicate on lane 0
        tv.push_back('{1, 1, 2'd3, 4'b0000, 0, 0});
        tv.push_back('{0, 0, 2'd0, 4'b0000, 0, 0});
        tv.push_back('{0, 0, 2'd0, 4'b0000, 0, 0});
        tv.push_back('{1, 1, 2'd0, 4'b0000, 0, 0});
        tv.push_back('{0, 0, 2'd0, 4'b0000, 0, 0});
        tv.push_back('{0, 0, 2'd0, 4'b0000, 0, 0});
        tv.push_back('{1, 0, 2'd2, 4'b0000, 0, 0});
        tv.push_back('{0, 0, 2'd0, 4'b0000, 0, 0});
        tv.push_back('{0, 0, 2'd0, 4'b0000, 0, 0});
        tv.push_back('{1, 0, 2'd1, 4'b1001, 1, 0});
        tv.push_back('{0, 0, 2'd0, 4'b1001, 0, 0});
        tv.push_back('{0, 0, 2'd0, 4'b1001, 0, 0});
        tv.push_back('{1, 1, 2'd0, 4'b1001, 0, 0});
        tv.push_back('{1, 0, 2'd0, 4'b1001, 0, 1});
        tv.push_back('{1, 1, 2'd1, 4'b1001, 0, 0});
        tv.push_back('{1, 1, 2'd2, 4'b1001, 0, 0});
        tv.push_back('{1, 1, 2'd3, 4'b1110, 1, 0});
        tv.push_back('{0, 0, 2'd0, 4'b1110, 0, 0});

        // auto select: two reset cycles then 1,0,1,1
        cyc(1, 0, 0, 2'd0, 0);
        cyc(1, 0, 0, 2'd0, 0);
        chk("rst_out", ifa.out, 0);
        chk("rst_ov", ifa.out_valid, 0);
        chk("rst_cur", ifa.cur_sel, 0);
        cyc(0, 1, 1, 2'd0, 0);
        cyc(0, 1, 0, 2'd0, 0);
        cyc(0, 1, 1, 2'd0, 0);
        chk("t1_ov_early", ifa.out_valid, 0);
        cyc(0, 1, 1, 2'd0, 0);
        chk("t1_out", ifa.out, 4'b1101);
        chk("t1_ov", ifa.out_valid, 1);
        chk("t1_cur", ifa.cur_sel, 0);
        cyc(0, 0, 0, 2'd0, 0);
        chk("t1_ov_pulse", ifa.out_valid, 0);

        cyc(1, 0, 0, 2'd0, 0);
        foreach (tv[i]) begin
            cyc(0, tv[i].v, tv[i].b, tv[i].s, 0);
            chk($sformatf("tbl%0d_out", i), ifm.out, tv[i].eo);
            chk($sformatf("tbl%0d_ov", i), ifm.out_valid, tv[i].eov);
            chk($sformatf("tbl%0d_dup", i), ifm.dup_err, tv[i].edup);
        end

        // frame_sync discards a partial frame
        cyc(1, 0, 0, 2'd0, 0);
        cyc(0, 1, 1, 2'd0, 0);
        cyc(0, 1, 1, 2'd0, 0);
        cyc(0, 1, 1, 2'd0, 1);
        chk("t4_dup", ifa.dup_err, 0);
        cyc(0, 1, 0, 2'd0, 0);
        cyc(0, 1, 1, 2'd0, 0);
        chk("t4_ov_early", ifa.out_valid, 0);
        cyc(0, 1, 0, 2'd0, 0);
        chk("t4_out", ifa.out, 4'b0101);
        chk("t4_ov", ifa.out_valid, 1);

        // reset in the middle of a frame
        cyc(0, 1, 1, 2'd0, 0);
        cyc(0, 1, 1, 2'd0, 0);
        cyc(0, 1, 1, 2'd0, 0);
        cyc(1, 1, 1, 2'd0, 0);
        chk("t5_rst_out", ifa.out, 0);
        chk("t5_rst_ov", ifa.out_valid, 0);
        cyc(0, 1, 0, 2'd0, 0);
        cyc(0, 1, 1, 2'd0, 0);
        cyc(0, 1, 1, 2'd0, 0);
        cyc(0, 1, 0, 2'd0, 0);
        chk("t5_out", ifa.out, 4'b0110);
        chk("t5_ov", ifa.out_valid, 1);

        // loopback from a 4:1 serialiser walking {in,sel} = 0..31
        cyc(1, 0, 0, 2'd0, 0);
        for (int k = 0; k < 32; k++) begin
            word = k >> 2;
            cyc(0, 1, word[k % 4], 2'(k % 4), 0);
            chk("t6_dup", ifa.dup_err, 0);
            if (k % 4 == 3) begin
                chk("t6_out", ifa.out, word);
                chk("t6_ov", ifa.out_valid, 1);
            end
        end

        // random traffic against the model
        for (int n = 0; n < 500; n++) begin
            cyc($urandom_range(0, 49) == 0,
                $urandom_range(0, 9) < 7,
                1'($urandom),
                2'($urandom),
                $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
